// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with request/ack memory port
//
// Sits between EX/MEM and MEM/WB. Legal loads/stores become one request on the
// data-memory port (IDLE -> WAIT -> DONE); the pipeline is stalled until the
// transaction completes or times out.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   valid_i, MemRead_i,
//   MemWrite_i, funct3_i,
//   ALUResult_i, MemWriteData_i,
//   RegWrite_i, MemtoReg_i       EX/MEM slot contents
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_be_o,
//   mem_wdata_o                  data-memory request (held stable in WAIT)
//   mem_ack_i, mem_rdata_i       data-memory completion and read word
//   stall_o                      freeze PC, IF/ID, ID/EX and EX/MEM
//   RegWrite_o, MemtoReg_o,
//   ALUResult_o, Memdata_o       to MEM/WB
//   err_o                        one-cycle misalign / illegal / timeout flag
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] MemWriteData_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] Memdata_o,
  output logic        err_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        timeout_q;
  logic        is_load_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] data_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic        mem_op;
  logic        misalign;
  logic        bad_load_f3;
  logic        bad_store_f3;
  logic        illegal;
  logic        start;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] rd_shift;
  logic [15:0] rd_half;
  logic [31:0] ld_fmt;

  // Access classification
  assign mem_op       = valid_i & (MemRead_i ^ MemWrite_i);
  assign misalign     = ((funct3_i[1:0] == 2'b01) & ALUResult_i[0]) |
                        ((funct3_i[1:0] == 2'b10) & (ALUResult_i[1:0] != 2'b00));
  assign bad_load_f3  = (funct3_i == 3'b011) | (funct3_i == 3'b110) | (funct3_i == 3'b111);
  assign bad_store_f3 = (funct3_i[2] == 1'b1) | (funct3_i[1:0] == 2'b11);
  assign illegal      = valid_i & ((MemRead_i & MemWrite_i) |
                                   (mem_op & (misalign |
                                              (MemRead_i & bad_load_f3) |
                                              (MemWrite_i & bad_store_f3))));
  assign start        = (state_q == S_IDLE) & mem_op & ~illegal;

  // Store lane placement
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = MemWriteData_i;
    case (funct3_i[1:0])
      2'b00: begin
        st_be    = 4'b0001 << ALUResult_i[1:0];
        st_wdata = {4{MemWriteData_i[7:0]}};
      end
      2'b01: begin
        st_be    = ALUResult_i[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{MemWriteData_i[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = MemWriteData_i;
      end
    endcase
  end

  // Load extraction uses the offset/size captured at request time
  assign rd_shift = mem_rdata_i >> {off_q, 3'b000};
  assign rd_half  = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  always_comb begin
    ld_fmt = mem_rdata_i;
    case (f3_q)
      3'b000:  ld_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  ld_fmt = {24'h000000, rd_shift[7:0]};
      3'b001:  ld_fmt = {{16{rd_half[15]}}, rd_half};
      3'b101:  ld_fmt = {16'h0000, rd_half};
      default: ld_fmt = mem_rdata_i;
    endcase
  end

  // Next state and combinational control
  always_comb begin
    state_d   = state_q;
    stall_o   = 1'b0;
    err_o     = 1'b0;
    mem_req_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        err_o = illegal;
        if (start) begin
          stall_o = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        mem_req_o = 1'b1;
        stall_o   = 1'b1;
        if (mem_ack_i || (cnt_q == LAST_WAIT)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        err_o   = timeout_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
      is_load_q <= 1'b0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
      data_q    <= 32'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      be_q      <= 4'b0000;
      wdata_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q    <= {ALUResult_i[31:2], 2'b00};
            we_q      <= MemWrite_i;
            be_q      <= MemWrite_i ? st_be : 4'b1111;
            wdata_q   <= MemWrite_i ? st_wdata : 32'd0;
            cnt_q     <= 8'd0;
            is_load_q <= MemRead_i;
            off_q     <= ALUResult_i[1:0];
            f3_q      <= funct3_i;
          end
        end
        S_WAIT: begin
          if (mem_ack_i) begin
            if (is_load_q) begin
              data_q <= ld_fmt;
            end
          end else if (cnt_q == LAST_WAIT) begin
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: timeout_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign Memdata_o   = data_q;
  assign MemtoReg_o  = MemtoReg_i;
  assign ALUResult_o = ALUResult_i;
  assign RegWrite_o  = RegWrite_i & valid_i & ~stall_o & ~err_o;

endmodule
